// File: rtl/switch_ingress_queue.sv
// Per-port ingress packet buffer in front of the crossbar: stores whole 4-word
// packets and replays one per frame strobe as a slot-aligned burst (or an idle frame).
module switch_ingress_queue #(
    parameter int WIDTH      = 15,
    parameter int PKT_WORDS  = 4,
    parameter int DEPTH_PKTS = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [WIDTH-1:0]              in_data,
    input  logic                          in_valid,
    input  logic                          in_sop,
    output logic                          in_ready,
    input  logic                          go,
    output logic [WIDTH-1:0]              out_data,
    output logic                          out_start,
    output logic                          out_valid,
    output logic [$clog2(DEPTH_PKTS):0]   pkt_count,
    output logic                          full,
    output logic                          err_drop
);
    localparam int PW = $clog2(DEPTH_PKTS);
    localparam int WW = $clog2(PKT_WORDS);
    localparam int CW = PW + 1;
    localparam logic [WW-1:0] LAST = WW'(PKT_WORDS - 1);

    typedef enum logic [1:0] {IDLE, SEND, PAD} state_t;
    typedef struct packed {
        logic             start;
        logic             valid;
        logic [WIDTH-1:0] data;
    } frm_t;

    logic [WIDTH-1:0] mem [DEPTH_PKTS*PKT_WORDS];
    state_t           state, nxt_state;
    logic [WW-1:0]    rs, nxt_rs, wi;
    logic [PW-1:0]    wpkt, rpkt;
    frm_t             frm, nxt_frm;
    logic             rdy_en, accept, bad_start, restart, commit, pop;

    // Reset holds in_ready low; rdy_en lifts it on the first edge after release.
    assign in_ready  = rdy_en & ((wi != '0) | (pkt_count < CW'(DEPTH_PKTS)));
    assign accept    = in_valid & in_ready;
    assign bad_start = accept & (wi == '0) & ~in_sop;
    assign restart   = accept & (wi != '0) & in_sop;
    assign commit    = accept & ~restart & (wi == LAST);
    assign full      = (pkt_count == CW'(DEPTH_PKTS));

    always_ff @(posedge clk) begin
        if (accept & ~bad_start)
            mem[{wpkt, restart ? WW'(0) : wi}] <= in_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wi       <= '0;
            wpkt     <= '0;
            rdy_en   <= 1'b0;
            err_drop <= 1'b0;
        end else begin
            rdy_en   <= 1'b1;
            err_drop <= bad_start | restart;
            // A restart reuses the same slot, so the partial words simply get overwritten.
            if (restart)
                wi <= WW'(1);
            else if (accept & ~bad_start)
                wi <= wi + 1'b1;
            if (commit)
                wpkt <= wpkt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            pkt_count <= '0;
        else if (commit & ~pop)
            pkt_count <= pkt_count + 1'b1;
        else if (pop & ~commit)
            pkt_count <= pkt_count - 1'b1;
    end

    // Frame engine: go is only honoured between frames, keeping all ports slot-aligned.
    always_comb begin
        nxt_state = state;
        nxt_rs    = rs;
        nxt_frm   = '0;
        pop       = 1'b0;
        if (state == IDLE || rs == LAST) begin
            nxt_rs = '0;
            if (go && pkt_count != '0) begin
                nxt_state     = SEND;
                nxt_frm.start = 1'b1;
                nxt_frm.valid = 1'b1;
                nxt_frm.data  = mem[{rpkt, WW'(0)}];
            end else if (go) begin
                nxt_state     = PAD;
                nxt_frm.start = 1'b1;
            end else begin
                nxt_state = IDLE;
            end
        end else begin
            nxt_rs = rs + 1'b1;
            if (state == SEND) begin
                nxt_frm.valid = 1'b1;
                nxt_frm.data  = mem[{rpkt, nxt_rs}];
                pop           = (nxt_rs == LAST);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            rs    <= '0;
            frm   <= '0;
            rpkt  <= '0;
        end else begin
            state <= nxt_state;
            rs    <= nxt_rs;
            frm   <= nxt_frm;
            if (pop)
                rpkt <= rpkt + 1'b1;
        end
    end

    assign out_data  = frm.data;
    assign out_start = frm.start;
    assign out_valid = frm.valid;
endmodule

// File: tb/tb_switch_ingress_queue.sv
// Scoreboard bench: a packet-queue reference model predicts frames, a negedge monitor compares.
module tb_switch_ingress_queue;
    localparam int W  = 15;
    localparam int NW = 4;
    localparam int D  = 4;

    logic         clk = 1'b0, rst = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0, in_sop = 1'b0, go = 1'b0;
    logic         in_ready, out_start, out_valid, full, err_drop;
    logic [W-1:0] out_data;
    logic [2:0]   pkt_count;

    switch_ingress_queue #(.WIDTH(W), .PKT_WORDS(NW), .DEPTH_PKTS(D)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop),
        .in_ready(in_ready), .go(go), .out_data(out_data), .out_start(out_start),
        .out_valid(out_valid), .pkt_count(pkt_count), .full(full), .err_drop(err_drop)
    );

    always #5 clk = ~clk;

    typedef logic [NW-1:0][W-1:0] pkt_t;
    typedef struct {
        logic [W-1:0] d;
        logic         st;
        logic         vl;
        int           ep;
    } exp_t;

    exp_t         sb[$];
    pkt_t         pkts[$];
    logic [W-1:0] cur[$];
    int  epoch = 0, rs_m = -1, pop_in = 0;
    bit  started = 0, err_m = 0;
    int  errors = 0, checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: committed packets live in a queue; a frame takes the head
    // and the head leaves the count three edges later (when slot 3 goes out).
    initial begin : model
        bit   rdy, samp, snd;
        pkt_t hd, p;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                pkts.delete(); cur.delete();
                started = 0; err_m = 0; rs_m = -1; pop_in = 0;
                epoch++;
            end else begin
                rdy  = started && (cur.size() != 0 || pkts.size() < D);
                samp = (rs_m == -1 || rs_m == 3) && go;
                snd  = samp && pkts.size() > 0;
                if (snd) hd = pkts[0];
                err_m = 0;
                if (pop_in > 0) begin
                    pop_in--;
                    if (pop_in == 0) void'(pkts.pop_front());
                end
                if (in_valid && rdy) begin
                    if (cur.size() == 0 && !in_sop) err_m = 1;
                    else begin
                        if (cur.size() != 0 && in_sop) begin
                            err_m = 1;
                            cur.delete();
                        end
                        cur.push_back(in_data);
                        if (cur.size() == NW) begin
                            for (int i = 0; i < NW; i++) p[i] = cur[i];
                            pkts.push_back(p);
                            cur.delete();
                        end
                    end
                end
                if (samp) begin
                    rs_m = 0;
                    if (snd) begin
                        for (int i = 0; i < NW; i++)
                            sb.push_back('{d: hd[i], st: (i == 0), vl: 1'b1, ep: epoch});
                        pop_in = 3;
                    end else
                        sb.push_back('{d: '0, st: 1'b1, vl: 1'b0, ep: epoch});
                end else if (rs_m == -1 || rs_m == 3)
                    rs_m = -1;
                else
                    rs_m++;
                started = 1;
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                while (sb.size() > 0 && sb[0].ep != epoch) void'(sb.pop_front());
                chk("in_ready", in_ready, started && (cur.size() != 0 || pkts.size() < D));
                chk("pkt_count", pkt_count, pkts.size());
                chk("full", full, pkts.size() == D);
                chk("err_drop", err_drop, err_m);
                if (out_start || out_valid) begin
                    if (sb.size() == 0)
                        chk("unexpected_frame", {out_start, out_valid}, 0);
                    else begin
                        e = sb.pop_front();
                        chk("out_data", out_data, e.d);
                        chk("out_start", out_start, e.st);
                        chk("out_valid", out_valid, e.vl);
                    end
                end else
                    chk("idle_data", out_data, 0);
            end
        end
    end

    task automatic cyc(input bit g);
        @(negedge clk);
        in_valid = 1'b0;
        go = g;
    endtask

    task automatic put(input logic [W-1:0] d, input bit sop);
        int t = 0;
        @(negedge clk);
        go = 1'b0;
        in_valid = 1'b0;
        while (!in_ready && t < 200) begin
            t++;
            @(negedge clk);
        end
        if (t >= 200) chk("ready_timeout", in_ready, 1);
        in_valid = 1'b1;
        in_data = d;
        in_sop = sop;
    endtask

    task automatic wr_pkt(input logic [W-1:0] a, b, c, d);
        put(a, 1); put(b, 0); put(c, 0); put(d, 0);
    endtask

    task automatic reset_zero_checks();
        chk("rst_out_data", out_data, 0);
        chk("rst_out_start", out_start, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_pkt_count", pkt_count, 0);
        chk("rst_full", full, 0);
        chk("rst_err_drop", err_drop, 0);
        chk("rst_in_ready", in_ready, 0);
    endtask

    initial begin
        int k;
        repeat (3) @(posedge clk);
        #1 reset_zero_checks();
        @(negedge clk); #2 rst = 1'b1;

        // single packet
        wr_pkt(15'h1111, 15'h2222, 15'h3333, 15'h4444);
        cyc(1); repeat (6) cyc(0);

        // async reset in the middle of a burst, then an idle frame
        wr_pkt(15'h0123, 15'h0456, 15'h0789, 15'h0abc);
        cyc(1); cyc(0);
        @(posedge clk); #2 rst = 1'b0;
        #1 reset_zero_checks();
        @(negedge clk); @(negedge clk); #2 rst = 1'b1;
        cyc(1); repeat (6) cyc(0);

        // fill to full, free one slot, then a fifth packet and drain with wrap
        for (int p = 0; p < 4; p++)
            wr_pkt(W'(16'h1000 + p*16), W'(16'h1001 + p*16), W'(16'h1002 + p*16), W'(16'h1003 + p*16));
        repeat (2) cyc(0);
        cyc(1);
        wr_pkt(15'h5005, 15'h5006, 15'h5007, 15'h5008);
        for (int g = 0; g < 5; g++) begin
            cyc(1); repeat (5) cyc(0);
        end

        // back-to-back frames with go held high
        for (int p = 0; p < 3; p++)
            wr_pkt(W'(16'h2200 + p), W'(16'h2210 + p), W'(16'h2220 + p), W'(16'h2230 + p));
        repeat (20) cyc(1);
        repeat (6) cyc(0);

        // framing errors
        put(15'h0aaa, 0); put(15'h0aaa, 0);
        put(15'h0100, 1); put(15'h0101, 0);
        wr_pkt(15'h0200, 15'h0201, 15'h0202, 15'h0203);
        cyc(1); repeat (6) cyc(0);

        // commit of a new packet on the same edge as the pop of the old one
        wr_pkt(15'h3300, 15'h3301, 15'h3302, 15'h3303);
        put(15'h4400, 1); put(15'h4401, 0); put(15'h4402, 0);
        cyc(1); cyc(0); cyc(0);
        put(15'h4403, 0);
        repeat (2) cyc(0);
        cyc(1); repeat (6) cyc(0);

        // randomized traffic with occasional framing errors
        k = 0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if (in_valid && in_ready) k = in_sop ? 1 : (k == 0 ? 0 : (k + 1) % NW);
            in_valid = ($urandom % 3) != 0;
            in_data = W'($urandom);
            in_sop = (k == 0) ^ (($urandom % 20) == 0);
            go = ($urandom % 6) == 0;
        end
        in_valid = 1'b0;
        go = 1'b0;
        repeat (10) cyc(0);
        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
